lsu_mem_if: RTL and testbench

LSU_MEM_IF -- requirements
Module: lsu_mem_if

---
 rtl/lsu_mem_if_pkg.sv | 54 +++++
 rtl/lsu_mem_if_lane_align.sv | 32 +++
 rtl/lsu_mem_if.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_if.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_if_pkg.sv
// Shared types and constants for the load/store unit memory interface.
// Size codes and opcodes are also consumed by the downstream load_logic stage.
package lsu_mem_if_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } lsu_state_e;

  typedef logic [1:0] lsu_size_t;

  localparam lsu_size_t SZ_BYTE = 2'b00;
  localparam lsu_size_t SZ_HALF = 2'b01;
  localparam lsu_size_t SZ_WORD = 2'b10;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Request captured in IDLE and replayed unchanged onto the memory bus.
  typedef struct packed {
    logic             we;
    lsu_size_t        size;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
  } lsu_req_t;

  // Size code 11 behaves as a word access.
  function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = addr_lo[0];
    end else if (size != SZ_BYTE) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_if_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data,
// plus the right-shift that brings the addressed load bytes down to bit 0.
module lsu_lane_align
  import lsu_mem_if_pkg::*;
(
  input  lsu_size_t        i_size,
  input  logic [1:0]       i_addr_lo,
  input  logic [XLEN-1:0]  i_st_data,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [BE_W-1:0]  o_be_c,
  output logic [XLEN-1:0]  o_wdata_c,
  output logic [XLEN-1:0]  o_ld_shift_c
);

  always_comb begin
    o_be_c    = 4'b1111;
    o_wdata_c = i_st_data;
    case (i_size)
      SZ_BYTE: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be_c    = 4'b0011 << i_addr_lo;
        o_wdata_c = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
    o_ld_shift_c = i_rdata >> {i_addr_lo, 3'b000};
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit bridge between the core pipeline and a ready/valid memory bus.
// One access in flight; the core is stalled until the access completes or fails.
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_addr,
  input  logic [XLEN-1:0]  i_st_data,
  output logic             o_stall,
  output logic [XLEN-1:0]  o_ld_data,
  output logic             o_ld_valid,
  output logic             o_misalign,
  output logic             o_bus_err,
  output logic             o_mem_valid,
  input  logic             i_mem_ready,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic             o_mem_we,
  output logic [BE_W-1:0]  o_mem_be,
  output logic [XLEN-1:0]  o_mem_wdata,
  input  logic             i_mem_rvalid,
  input  logic [XLEN-1:0]  i_mem_rdata,
  input  logic             i_mem_err
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_live_c;
  logic              misalign_c;
  logic              timeout_c;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ld_shift_c;
  logic              unused_funct3_sign;

  // funct3[2] only selects sign/zero extension, which happens downstream.
  assign unused_funct3_sign = i_funct3[2];

  // Reset also masks the request so no combinational output leaks during reset.
  assign req_live_c = i_req & i_reset;
  assign misalign_c = is_misaligned(lsu_size_t'(i_funct3[1:0]), i_addr[1:0]);
  assign timeout_c  = ((state_q == ST_REQ) || (state_q == ST_WAIT_RSP)) &&
                      (cnt_q == CNT_W'(TIMEOUT));

  lsu_lane_align u_lane_align (
    .i_size       (req_q.size),
    .i_addr_lo    (req_q.addr[1:0]),
    .i_st_data    (req_q.data),
    .i_rdata      (i_mem_rdata),
    .o_be_c       (be_c),
    .o_wdata_c    (wdata_c),
    .o_ld_shift_c (ld_shift_c)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ld_data_d   = ld_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q + CNT_W'(1);
    o_stall     = 1'b0;
    o_misalign  = 1'b0;
    o_bus_err   = 1'b0;
    o_ld_valid  = 1'b0;
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_live_c) begin
          if (misalign_c) begin
            o_misalign = 1'b1;
          end else begin
            o_stall = 1'b1;
            req_d   = '{we: i_we, size: lsu_size_t'(i_funct3[1:0]),
                        addr: i_addr, data: i_st_data};
            err_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {req_q.addr[XLEN-1:2], 2'b00};
        o_mem_we    = req_q.we;
        o_mem_be    = be_c;
        o_mem_wdata = wdata_c;
        o_stall     = req_live_c;
        if (i_mem_ready) begin
          cnt_d = '0;
          if (req_q.we) begin
            err_d   = i_mem_err;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end else if (timeout_c) begin
          o_bus_err = 1'b1;
          o_stall   = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_WAIT_RSP: begin
        o_stall = req_live_c;
        if (i_mem_rvalid) begin
          err_d     = i_mem_err;
          ld_data_d = i_mem_err ? '0 : ld_shift_c;
          state_d   = ST_DONE;
        end else if (timeout_c) begin
          o_bus_err = 1'b1;
          o_stall   = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_DONE: begin
        o_ld_valid = ~req_q.we & ~err_q;
        o_bus_err  = err_q;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ld_data = ld_data_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: table of single transactions plus
// hand-written timeout and mid-transaction reset sequences.
module tb_lsu_mem_if;

  logic        clk;
  logic        i_reset;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_stall;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misalign;
  logic        o_bus_err;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;

  int checks = 0;
  int errors = 0;

  lsu_mem_if #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_st_data    (i_st_data),
    .o_stall      (o_stall),
    .o_ld_data    (o_ld_data),
    .o_ld_valid   (o_ld_valid),
    .o_misalign   (o_misalign),
    .o_bus_err    (o_bus_err),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_err    (i_mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        err;
    int          dly;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
    logic        e_lv;
    logic        e_berr;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input logic err,
                              input int dly, input logic mis, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_ld, input logic e_lv, input logic e_berr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.err = err;
    v.dly = dly; v.mis = mis; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_ld = e_ld; v.e_lv = e_lv; v.e_berr = e_berr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(posedge clk); #1;
    i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr; i_st_data = v.sdata;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_err = 1'b0;
    @(negedge clk);
    if (v.mis) begin
      chk($sformatf("v%0d_misalign", i), 32'(o_misalign), 32'd1);
      chk($sformatf("v%0d_mis_stall", i), 32'(o_stall), 32'd0);
      chk($sformatf("v%0d_mis_valid", i), 32'(o_mem_valid), 32'd0);
      @(posedge clk); #1;
      i_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_mis_valid_after", i), 32'(o_mem_valid), 32'd0);
      chk($sformatf("v%0d_mis_pulse_end", i), 32'(o_misalign), 32'd0);
      return;
    end
    chk($sformatf("v%0d_idle_stall", i), 32'(o_stall), 32'd1);
    for (int k = 0; k <= v.dly; k++) begin
      @(posedge clk); #1;
      i_mem_ready = (k == v.dly);
      i_mem_err   = v.we && v.err && (k == v.dly);
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_valid", i, k), 32'(o_mem_valid), 32'd1);
      chk($sformatf("v%0d_c%0d_addr", i, k), o_mem_addr, v.e_addr);
      chk($sformatf("v%0d_c%0d_we", i, k), 32'(o_mem_we), 32'(v.we));
      chk($sformatf("v%0d_c%0d_be", i, k), 32'(o_mem_be), 32'(v.e_be));
      chk($sformatf("v%0d_c%0d_wdata", i, k), o_mem_wdata, v.e_wdata);
      chk($sformatf("v%0d_c%0d_stall", i, k), 32'(o_stall), 32'd1);
    end
    @(posedge clk); #1;
    i_mem_ready = 1'b0; i_mem_err = 1'b0;
    if (!v.we) begin
      i_mem_rvalid = 1'b1; i_mem_rdata = v.rdata; i_mem_err = v.err;
      @(negedge clk);
      chk($sformatf("v%0d_wait_valid", i), 32'(o_mem_valid), 32'd0);
      chk($sformatf("v%0d_wait_stall", i), 32'(o_stall), 32'd1);
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0; i_mem_err = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_done_ld_valid", i), 32'(o_ld_valid), 32'(v.e_lv));
    chk($sformatf("v%0d_done_bus_err", i), 32'(o_bus_err), 32'(v.e_berr));
    chk($sformatf("v%0d_done_stall", i), 32'(o_stall), 32'd0);
    if (!v.we) chk($sformatf("v%0d_ld_data", i), o_ld_data, v.e_ld);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_ld_valid", i), 32'(o_ld_valid), 32'd0);
    chk($sformatf("v%0d_idle_bus_err", i), 32'(o_bus_err), 32'd0);
  endtask

  // Timeout while stuck in REQ (in_wait=0) or WAIT_RSP (in_wait=1), TIMEOUT=4.
  task automatic timeout_seq(input logic in_wait);
    string tag;
    tag = in_wait ? "to_wait" : "to_req";
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0050; i_st_data = '0;
    @(negedge clk);
    @(posedge clk); #1;
    if (in_wait) begin
      i_mem_ready = 1'b1;
      @(posedge clk); #1;
      i_mem_ready = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d_valid", tag, k), 32'(o_mem_valid), 32'(!in_wait));
      chk($sformatf("%s_c%0d_bus_err", tag, k), 32'(o_bus_err), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("%s_c%0d_stall", tag, k), 32'(o_stall), (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_ld_valid", tag, k), 32'(o_ld_valid), 32'd0);
      @(posedge clk); #1;
    end
    i_req = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_idle_valid", tag), 32'(o_mem_valid), 32'd0);
    chk($sformatf("%s_idle_bus_err", tag), 32'(o_bus_err), 32'd0);
    chk($sformatf("%s_idle_ld_valid", tag), 32'(o_ld_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    //            we    f3      addr          sdata         rdata         err  dly mis  e_addr        e_be     e_wdata       e_ld          lv    berr
    vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'hAABB_CCDD, 1'b0, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_00AA, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,        1'b0, 0, 1'b0, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h1122_3344, 1'b0, 3, 1'b0, 32'h0000_0400, 4'b1111, 32'h0,        32'h1122_3344, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0012, 32'h0,        32'hCAFE_BABE, 1'b0, 1, 1'b0, 32'h0000_0010, 4'b1100, 32'h0,        32'h0000_CAFE, 1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 3'b000, 32'h0000_0007, 32'h0000_005A, 32'h0,        1'b0, 0, 1'b0, 32'h0000_0004, 4'b1000, 32'h5A5A_5A5A, 32'h0,        1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        1'b1, 2, 1'b0, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h1234_5678, 1'b1, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0,        32'h0,        1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 3'b001, 32'h0000_0033, 32'h0,        32'h0,        1'b0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 3'b010, 32'h0000_0042, 32'h0,        32'h0,        1'b0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
    vecs[10] = mk(1'b0, 3'b100, 32'h0000_0002, 32'h0,        32'h00FF_8000, 1'b0, 0, 1'b0, 32'h0000_0000, 4'b0100, 32'h0,        32'h0000_00FF, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 3'b011, 32'h0000_0008, 32'h0,        32'h0BAD_F00D, 1'b0, 0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0,        32'h0BAD_F00D, 1'b1, 1'b0);

    i_reset = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_st_data = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_err = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_be", 32'(o_mem_be), 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    chk("rst_ld_data", o_ld_data, 32'd0);
    chk("rst_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    timeout_seq(1'b1);
    timeout_seq(1'b0);

    // Reset mid-load while the response is outstanding, then a late rvalid.
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0060;
    @(posedge clk); #1;
    i_mem_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_wait_stall", 32'(o_stall), 32'd1);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", 32'(o_stall), 32'd0);
    chk("mid_rst_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("mid_rst_ld_data", o_ld_data, 32'd0);
    chk("mid_rst_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("mid_rst_bus_err", 32'(o_bus_err), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b1; i_req = 1'b0;
    @(posedge clk); #1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rvalid_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("late_rvalid_mem_valid", 32'(o_mem_valid), 32'd0);
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_after_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("late_after_ld_data", o_ld_data, 32'd0);
    chk("late_after_stall", 32'(o_stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
